// File: rtl/udp_axis_traffic_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : traffic_gen_pkg                                                |
// | Purpose   : Shared types and helpers for the UDP AXI-Stream traffic        |
// |             generator and its loopback checker.                            |
// | Contents  : tg_state_t    - FSM encoding (IDLE, SEND, GAP)                 |
// |             pattern_byte  - payload byte k of a frame with sequence seq    |
// |             sweep_len     - beat count of frame n in a MIN..MAX sweep      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package traffic_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tg_state_t;

  // Byte k of frame seq is (seq + k) mod 256; only the low byte of k matters.
  function automatic logic [7:0] pattern_byte(input logic [7:0] seq, input logic [31:0] k);
    return seq + k[7:0];
  endfunction

  function automatic logic [15:0] sweep_len(input logic [31:0] n,
                                            input int unsigned min_w,
                                            input int unsigned max_w);
    int unsigned span;
    span = max_w - min_w + 1;
    return 16'(min_w + (n % span));
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_axis_traffic_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : udp_axis_traffic_chk                                           |
// | Purpose   : Verifies frames returning from a UDP loopback against the      |
// |             generator's sequence/length sweep.                             |
// | Ports     : clk, rst         - clock, synchronous active-high reset        |
// |             start            - restarts the expected sequence at frame 0   |
// |             s_axis_*         - returned stream (always accepted)           |
// |             rx_frames_ok     - frames that matched                         |
// |             rx_err_count     - frames that failed, saturating              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module udp_axis_traffic_chk
  import traffic_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_WORDS  = 1,
  parameter int MAX_WORDS  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [31:0]           rx_frames_ok,
  output logic [15:0]           rx_err_count
);

  logic [31:0] exp_seq_q, exp_seq_d;
  logic [15:0] exp_len_q, exp_len_d;
  logic [15:0] beat_q, beat_d;
  logic [7:0]  base_q, base_d;
  logic        bad_q, bad_d;
  logic [31:0] ok_q, ok_d;
  logic [15:0] err_q, err_d;
  logic        mism;
  logic        frame_bad;

  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != pattern_byte(base_q, 32'(i))))
        mism = 1'b1;
    end
  end

  // Earlier beats' errors are folded into bad_q; the length test uses the
  // beat index of the tlast beat.
  assign frame_bad = bad_q | mism | s_axis_tuser | ((beat_q + 16'd1) != exp_len_q);

  always_comb begin
    exp_seq_d = exp_seq_q;
    exp_len_d = exp_len_q;
    beat_d    = beat_q;
    base_d    = base_q;
    bad_d     = bad_q;
    ok_d      = ok_q;
    err_d     = err_q;
    if (start) begin
      exp_seq_d = '0;
      exp_len_d = sweep_len(32'd0, MIN_WORDS, MAX_WORDS);
      beat_d    = '0;
      base_d    = '0;
      bad_d     = 1'b0;
      ok_d      = '0;
      err_d     = '0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        if (frame_bad) err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        else           ok_d  = ok_q + 32'd1;
        exp_seq_d = exp_seq_q + 32'd1;
        exp_len_d = (exp_len_q == 16'(MAX_WORDS)) ? 16'(MIN_WORDS) : exp_len_q + 16'd1;
        beat_d    = '0;
        base_d    = exp_seq_d[7:0];
        bad_d     = 1'b0;
      end else begin
        beat_d = beat_q + 16'd1;
        base_d = base_q + 8'(KEEP_WIDTH);
        bad_d  = bad_q | mism;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_seq_q <= '0;
      exp_len_q <= sweep_len(32'd0, MIN_WORDS, MAX_WORDS);
      beat_q    <= '0;
      base_q    <= '0;
      bad_q     <= 1'b0;
      ok_q      <= '0;
      err_q     <= '0;
    end else begin
      exp_seq_q <= exp_seq_d;
      exp_len_q <= exp_len_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      bad_q     <= bad_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign rx_frames_ok = ok_q;
  assign rx_err_count = err_q;

endmodule
`default_nettype wire

// File: rtl/udp_axis_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : udp_axis_traffic_gen                                           |
// | Purpose   : AXI-Stream frame generator for UDP bring-up; frame length      |
// |             sweeps MIN_WORDS..MAX_WORDS, payload byte k of frame n is      |
// |             (n + k) mod 256. Optional loopback checker.                    |
// | Macro     : TRAFFIC_GEN_CHECKER_EN - builds udp_axis_traffic_chk; when     |
// |             undefined s_axis_* are unused and rx counters read 0.          |
// | Ports     : tx_axis_aclk/tx_axis_reset - clock, sync active-high reset     |
// |             cfg_start (pulse), cfg_stop (level), cfg_frame_limit (0=run    |
// |             forever), cfg_last_bytes (valid bytes in last beat, 0=all)     |
// |             m_axis_*  - generated stream; s_axis_* - returned stream       |
// |             busy, frames_sent, rx_frames_ok, rx_err_count - status         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module udp_axis_traffic_gen
  import traffic_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_WORDS  = 1,
  parameter int MAX_WORDS  = 20,
  parameter int IFG_CYCLES = 1
) (
  input  logic                          tx_axis_aclk,
  input  logic                          tx_axis_reset,
  input  logic                          cfg_start,
  input  logic                          cfg_stop,
  input  logic [31:0]                   cfg_frame_limit,
  input  logic [$clog2(KEEP_WIDTH):0]   cfg_last_bytes,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  output logic                          busy,
  output logic [31:0]                   frames_sent,
  output logic [31:0]                   rx_frames_ok,
  output logic [15:0]                   rx_err_count
);

  localparam int LB_W = $clog2(KEEP_WIDTH) + 1;

  tg_state_t   state_q, state_d;
  // frames_sent doubles as the sequence number n of the frame in flight.
  logic [31:0] frames_sent_q, frames_sent_d;
  logic [15:0] len_q, len_d;
  logic [15:0] beat_q, beat_d;
  logic [7:0]  base_q, base_d;
  logic [15:0] gap_q, gap_d;
  logic [LB_W-1:0] last_bytes_q, last_bytes_d;

  logic last_beat;
  logic stop_now;
  logic start_run;

  assign last_beat = (beat_q == (len_q - 16'd1));
  assign stop_now  = cfg_stop ||
                     ((cfg_frame_limit != 32'd0) && ((frames_sent_q + 32'd1) == cfg_frame_limit));
  assign start_run = (state_q == IDLE) && cfg_start;

  always_comb begin
    state_d       = state_q;
    frames_sent_d = frames_sent_q;
    len_d         = len_q;
    beat_d        = beat_q;
    base_d        = base_q;
    gap_d         = gap_q;
    last_bytes_d  = last_bytes_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d       = SEND;
          frames_sent_d = '0;
          len_d         = sweep_len(32'd0, MIN_WORDS, MAX_WORDS);
          beat_d        = '0;
          base_d        = '0;
          // Latched so tkeep cannot change under a stalled last beat.
          last_bytes_d  = cfg_last_bytes;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (last_beat) begin
            frames_sent_d = frames_sent_q + 32'd1;
            len_d  = (len_q == 16'(MAX_WORDS)) ? 16'(MIN_WORDS) : len_q + 16'd1;
            beat_d = '0;
            base_d = frames_sent_d[7:0];
            gap_d  = '0;
            if (stop_now)             state_d = IDLE;
            else if (IFG_CYCLES == 0) state_d = SEND;
            else                      state_d = GAP;
          end else begin
            beat_d = beat_q + 16'd1;
            base_d = base_q + 8'(KEEP_WIDTH);
          end
        end
      end
      GAP: begin
        if (gap_q == 16'(IFG_CYCLES - 1)) state_d = SEND;
        else                              gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_reset) begin
      state_q       <= IDLE;
      frames_sent_q <= '0;
      len_q         <= sweep_len(32'd0, MIN_WORDS, MAX_WORDS);
      beat_q        <= '0;
      base_q        <= '0;
      gap_q         <= '0;
      last_bytes_q  <= '0;
    end else begin
      state_q       <= state_d;
      frames_sent_q <= frames_sent_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      gap_q         <= gap_d;
      last_bytes_q  <= last_bytes_d;
    end
  end

  // Beat contents derive only from registers that move on a handshake,
  // so they hold while the sink stalls. Outputs read zero when idle.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    if (state_q == SEND) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        m_axis_tdata[8*i +: 8] = pattern_byte(base_q, 32'(i));
        m_axis_tkeep[i] = !last_beat || (last_bytes_q == '0) || (32'(i) < 32'(last_bytes_q));
      end
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = (state_q == SEND) && last_beat;
  assign busy          = (state_q != IDLE);
  assign frames_sent   = frames_sent_q;

`ifdef TRAFFIC_GEN_CHECKER_EN
  udp_axis_traffic_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .MIN_WORDS  (MIN_WORDS),
    .MAX_WORDS  (MAX_WORDS)
  ) u_chk (
    .clk           (tx_axis_aclk),
    .rst           (tx_axis_reset),
    .start         (start_run),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .rx_frames_ok  (rx_frames_ok),
    .rx_err_count  (rx_err_count)
  );
`else
  logic unused_rx;
  assign unused_rx    = ^{s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
                          s_axis_tuser, start_run};
  assign rx_frames_ok = '0;
  assign rx_err_count = '0;
`endif

endmodule
`default_nettype wire
